// File: rtl/la_ioring_ctrl_if.sv
// IO ring segment control bus: power request, supply-good, pad config in;
// ring bus and status out.
interface la_ioring_ctrl_if #(parameter int RINGW = 8);
  logic             en;
  logic             vddok;
  logic [RINGW-4:0] cfg;
  logic [RINGW-1:0] ring;
  logic             ready;
  logic             fault;
  logic [2:0]       state;

  modport master (output en, vddok, cfg, input ring, ready, fault, state);
  modport slave  (input en, vddok, cfg, output ring, ready, fault, state);
endinterface

// File: rtl/la_ioring_ctrl.sv
// Power-up/down sequencer for one IO ring segment: supply settle, pad POR,
// isolation release, output enable; safe FAULT on supply loss or timeout.
module la_ioring_ctrl #(
  parameter        PROP    = "DEFAULT",
  parameter        SIDE    = "NO",
  parameter int    RINGW   = 8,
  parameter int    SETTLE  = 16,
  parameter int    PORCYC  = 8,
  parameter int    ISOCYC  = 4,
  parameter int    TIMEOUT = 1024
) (
  input logic            clk,
  input logic            nreset,
  la_ioring_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    OFF = 3'd0, WAIT = 3'd1, POR = 3'd2, ISO = 3'd3,
    ACTIVE = 3'd4, DOWN = 3'd5, FAULT = 3'd6
  } state_t;

  localparam int M0   = (SETTLE > PORCYC) ? SETTLE : PORCYC;
  localparam int M1   = (ISOCYC > TIMEOUT) ? ISOCYC : TIMEOUT;
  localparam int MAXC = (M0 > M1) ? M0 : M1;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] POR_LAST = CW'(PORCYC - 1);
  localparam logic [CW-1:0] ISO_LAST = CW'(ISOCYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] DN_LAST  = CW'(1);

  // PROP/SIDE only steer library and physical mapping; nothing here depends on them.
  localparam bit PARAM_OK = (RINGW >= 4) && (PROP != "") &&
    (SIDE == "NO" || SIDE == "SO" || SIDE == "EA" || SIDE == "WE");
  logic unused_params;
  assign unused_params = PARAM_OK;

  state_t           state_q, nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CW-1:0]    settle, settle_nxt;
  logic             vdd_m, vdd_s;
  logic [RINGW-4:0] cfg_q, cfg_nxt;
  logic [RINGW-1:0] ring_q, ring_nxt;
  logic             ready_q, fault_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= OFF;
      cnt     <= '0;
      settle  <= '0;
      vdd_m   <= 1'b0;
      vdd_s   <= 1'b0;
      cfg_q   <= '0;
      ring_q  <= '0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= nxt;
      cnt     <= cnt_nxt;
      settle  <= settle_nxt;
      vdd_m   <= bus.vddok;
      vdd_s   <= vdd_m;
      cfg_q   <= cfg_nxt;
      ring_q  <= ring_nxt;
      ready_q <= (nxt == ACTIVE);
      fault_q <= (nxt == FAULT);
    end
  end

  always_comb begin
    nxt        = state_q;
    cnt_nxt    = cnt;
    settle_nxt = settle;
    case (state_q)
      OFF:    if (bus.en) nxt = WAIT;
      WAIT: begin
        cnt_nxt    = cnt + 1'b1;
        settle_nxt = vdd_s ? settle + 1'b1 : '0;
        if (!bus.en)                         nxt = OFF;
        else if (vdd_s && settle == SET_LAST) nxt = POR;
        else if (cnt == TO_LAST)             nxt = FAULT;
      end
      POR: begin
        cnt_nxt = cnt + 1'b1;
        if (!vdd_s)                nxt = FAULT;
        else if (!bus.en)          nxt = DOWN;
        else if (cnt == POR_LAST)  nxt = ISO;
      end
      ISO: begin
        cnt_nxt = cnt + 1'b1;
        if (!vdd_s)                nxt = FAULT;
        else if (!bus.en)          nxt = DOWN;
        else if (cnt == ISO_LAST)  nxt = ACTIVE;
      end
      ACTIVE: begin
        if (!vdd_s)       nxt = FAULT;
        else if (!bus.en) nxt = DOWN;
      end
      DOWN: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == DN_LAST) nxt = OFF;
      end
      FAULT:   if (!bus.en) nxt = OFF;
      default: nxt = FAULT;
    endcase
    if (nxt != state_q) begin
      cnt_nxt    = '0;
      settle_nxt = '0;
    end

    cfg_nxt = cfg_q;
    if (nxt == ISO && state_q != ISO) cfg_nxt = bus.cfg;
    if (nxt == OFF || nxt == FAULT)   cfg_nxt = '0;

    // Ring bits: {config, oe, por_n, iso_n}; DOWN drops oe first, then por_n/iso_n.
    ring_nxt = '0;
    case (nxt)
      ISO:     ring_nxt = {cfg_nxt, 3'b011};
      ACTIVE:  ring_nxt = {cfg_nxt, 3'b111};
      DOWN:    ring_nxt = (state_q != DOWN) ? {cfg_nxt, 3'b011} : {cfg_nxt, 3'b000};
      default: ring_nxt = '0;
    endcase
  end

  assign bus.ring  = ring_q;
  assign bus.ready = ready_q;
  assign bus.fault = fault_q;
  assign bus.state = state_q;
endmodule

// File: doc/la_ioring_ctrl.md
Name: la_ioring_ctrl

Overview:
- Power-up and power-down sequencer that drives the IO ring control bus (RINGW bits) into one ring segment.
- Sits upstream of the pad/supply cells in that segment; ring cut cells bound the segment.
- Sequences supply settle, pad POR, isolation release and global output enable.
- Latches static pad configuration onto the upper ring bits and enters a safe FAULT state on supply loss or timeout.

Parameters:
- PROP, "DEFAULT", cell property passed through for library mapping.
- SIDE, "NO", ring side ("NO", "SO", "EA", "WE"); no functional effect, carried for physical mapping.
- RINGW, 8, width of io ring bus; minimum 4.
- SETTLE, 16, consecutive cycles synced vddok must stay high before POR.
- PORCYC, 8, cycles por_n held low.
- ISOCYC, 4, cycles between isolation release and output enable.
- TIMEOUT, 1024, maximum cycles in WAIT_SUPPLY before FAULT.

Ports:
- clk  input  1  core clock.
- nreset  input  1  synchronous active-low reset.
- en  input  1  request segment power-up (level); low requests power-down.
- vddok  input  1  supply-good from ring detector; asynchronous to clk.
- cfg  input  RINGW-3  static pad configuration (drive, slew, pull).
- ring  output  RINGW  ring bus. Bit mapping:
  - [0] iso_n, active-low isolation.
  - [1] por_n.
  - [2] oe, global output enable.
  - [RINGW-1:3] config.
- ready  output  1  segment ACTIVE.
- fault  output  1  segment in FAULT.
- state  output  3  current FSM state, for debug.

Behaviour:
- Reset is synchronous and active-low. With nreset=0 at a clk edge:
  - state=OFF; ring=0 (isolated, in POR, oe off, config 0); ready=0; fault=0.
  - Counter and both synchronizer flops are cleared.
- vddok passes through a 2-flop synchronizer; vddok_s is its output. All decisions use vddok_s.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state change.
- Counter width is clog2(max(SETTLE, PORCYC, ISOCYC, TIMEOUT))+1. The counter clears on every state change.
- State encodings: OFF=0, WAIT=1, POR=2, ISO=3, ACTIVE=4, DOWN=5, FAULT=6.
- OFF: ring=0. If en=1, go to WAIT.
- WAIT:
  - ring=0.
  - settle count increments while vddok_s=1 and clears to 0 when vddok_s=0.
  - If the settle count reaches SETTLE, go to POR.
  - Otherwise, if the total time in WAIT reaches TIMEOUT, go to FAULT.
  - Use two counters or a settle counter plus a timeout counter.
- POR:
  - ring: iso_n=0, por_n=0, oe=0.
  - After PORCYC cycles, go to ISO.
- ISO:
  - ring: iso_n=1, por_n=1, oe=0.
  - config bits load cfg on entry and are held constant until OFF.
  - After ISOCYC cycles, go to ACTIVE.
- ACTIVE: iso_n=1, por_n=1, oe=1, ready=1. cfg changes are ignored while ACTIVE.
- DOWN:
  - oe=0 and ready=0 on the entry edge.
  - The next edge drives iso_n=0 and por_n=0.
  - The following edge goes to OFF with config cleared.
  - Total: 2 cycles in DOWN.
- FAULT: ring=0, ready=0, fault=1. Stays in FAULT until en=0, then goes to OFF with fault cleared on that edge.
- Priority from WAIT through ACTIVE:
  1. vddok_s=0 in POR, ISO or ACTIVE: go to FAULT.
  2. en=0 in WAIT: go to OFF. en=0 in POR, ISO or ACTIVE: go to DOWN.
  3. Normal progression.
- In DOWN, en and vddok are ignored until OFF is reached. A re-request in OFF then restarts the full sequence.
- Simultaneous vddok loss and en drop in ACTIVE: go to FAULT.
- nreset low mid-sequence forces the reset values on that edge. No graceful power-down is performed.

Test Plan:
- Nominal power-up, defaults, vddok held high for ≥3 cycles before en rises:
  - ready rises exactly 29 edges after the first edge sampling en=1 (1+16+8+4).
  - por_n rises at edge 25; oe=1 coincides with ready.
- Power-down from ACTIVE (en low):
  - oe and ready fall on the next edge.
  - iso_n and por_n fall one edge later.
  - state=OFF after 3 edges total; ring=0.
- vddok glitch low for 1 cycle during WAIT at settle count 10: settle restarts; ready is delayed by 11 cycles relative to nominal.
- vddok never high, en=1: FAULT at edge 1+1024; fault=1, ring=0. Then en=0 → OFF next edge, fault=0.
- vddok drop in ACTIVE:
  - FAULT 3 edges after the drop (2 sync + 1); ring=0 immediately on entry.
  - Same result when en drops on the same cycle.
- cfg=5'b10110 at ISO entry, then cfg changes in ACTIVE: ring[7:3] stays 10110. nreset=0 during POR gives ring=0 and state=OFF on the next edge.
